// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing controller for a UART receiver: start detection, oversample/bit
// counting, checker strobes and frame acceptance. Optional sticky error status under UART_RX_ERR_STATUS_EN.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
`ifdef UART_RX_ERR_STATUS_EN
  input  logic                  err_clr,
  output logic [2:0]            err_status,
`endif
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(8);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PRESCALE_W-1:0]   p_lat_q, p_lat_d;
  logic                    par_hold_q, par_hold_d;
  logic [PRESCALE_W-1:0]   samp_pt;
  logic                    last_edge;
  logic                    start_frame;

  assign last_edge = (edge_cnt == p_lat_q - PRESCALE_W'(1));
  // Strobes are registered, so they are decoded from the next-cycle state and count.
  assign samp_pt   = (p_lat_d >> 1) + PRESCALE_W'(1);

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    edge_d      = edge_cnt;
    bit_d       = bit_q;
    p_lat_d     = p_lat_q;
    par_hold_d  = par_hold_q;
    start_frame = 1'b0;

    if (state_q != IDLE) begin
      edge_d = last_edge ? '0 : edge_cnt + PRESCALE_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!rx_in) start_frame = 1'b1;
      end
      START: begin
        if (last_edge) state_d = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (last_edge) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          state_d    = STOP;
          par_hold_d = par_err;
        end
      end
      STOP: begin
        if (last_edge) state_d = DONE;
      end
      DONE: begin
        if (!rx_in) start_frame = 1'b1;
        else        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new frame latches its own prescale and clears all per-frame history.
    if (start_frame) begin
      state_d    = START;
      edge_d     = '0;
      bit_d      = '0;
      par_hold_d = 1'b0;
      p_lat_d    = (prescale < MIN_PRESCALE) ? MIN_PRESCALE : prescale;
    end

    if (state_d == IDLE) begin
      edge_d = '0;
      bit_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      edge_cnt    <= '0;
      bit_q       <= '0;
      p_lat_q     <= MIN_PRESCALE;
      par_hold_q  <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt    <= edge_d;
      bit_q       <= bit_d;
      p_lat_q     <= p_lat_d;
      par_hold_q  <= par_hold_d;
      dat_samp_en <= (state_d != IDLE);
      strt_chk_en <= (state_d == START)  && (edge_d == samp_pt);
      deser_en    <= (state_d == DATA)   && (edge_d == samp_pt);
      par_chk_en  <= (state_d == PARITY) && (edge_d == samp_pt);
      stp_chk_en  <= (state_d == STOP)   && (edge_d == samp_pt);
      data_valid  <= (state_d == DONE)   && !(par_hold_d || stp_err);
    end
  end

`ifdef UART_RX_ERR_STATUS_EN
  logic strt_fail, par_fail, stp_fail;

  assign strt_fail = (state_q == START)  && last_edge && strt_glitch;
  assign par_fail  = (state_q == PARITY) && last_edge && par_err;
  assign stp_fail  = (state_q == STOP)   && last_edge && stp_err;

  // Clear has priority over a set arriving in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_status <= '0;
    end else if (err_clr) begin
      err_status <= '0;
    end else begin
      err_status <= err_status | {strt_fail, par_fail, stp_fail};
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: each frame pushes its expected strobe/valid
// events with hand-derived cycle numbers; a monitor pops them as the DUT pulses.
module tb_uart_rx_ctrl;

  localparam int PW = 6;

  typedef enum int {EV_STRT, EV_DATA, EV_PAR, EV_STOP, EV_VALID} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } ev_s;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic          strt_chk_en;
  logic          deser_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          data_valid;
`ifdef UART_RX_ERR_STATUS_EN
  logic          err_clr = 1'b0;
  logic [2:0]    err_status;
`endif

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_s sb[$];
  bit  cfg_glitch, cfg_perr, cfg_serr;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
`ifdef UART_RX_ERR_STATUS_EN
    .err_clr     (err_clr),
    .err_status  (err_status),
`endif
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input ev_e k, input int c);
    ev_s e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Start edge sampled at the end of cycle t; bit n of the frame spans t+1+n*p .. t+(n+1)*p.
  task automatic push_frame(input int t, input int p, input bit par, input bit glitch,
                            input bit perr, input bit serr);
    int s;
    int stop_bit;
    s = p / 2 + 1;
    push_ev(EV_STRT, t + 1 + s);
    if (!glitch) begin
      for (int k = 0; k < 8; k++) push_ev(EV_DATA, t + 1 + (k + 1) * p + s);
      stop_bit = par ? 10 : 9;
      if (par) push_ev(EV_PAR, t + 1 + 9 * p + s);
      push_ev(EV_STOP, t + 1 + stop_bit * p + s);
      if (!(par && perr) && !serr) push_ev(EV_VALID, t + 1 + (stop_bit + 1) * p);
    end
  endtask

  task automatic expect_ev(input ev_e k);
    ev_s e;
    check({k.name(), "_expected"}, int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({k.name(), "_kind"}, int'(k), int'(e.kind));
      check({k.name(), "_cycle"}, cyc, e.cyc);
    end
  endtask

  // Called just after a posedge; drives the whole frame on rx_in, then idles for gap cycles.
  task automatic send_frame(input logic [7:0] d, input int p_in, input bit par, input bit glitch,
                            input bit perr, input bit serr, input int p_switch, input int gap);
    int t;
    int pe;
    int nb;
    logic [10:0] bits;
    pe = (p_in < 8) ? 8 : p_in;
    cfg_glitch  = glitch;
    cfg_perr    = perr;
    cfg_serr    = serr;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
    prescale    = PW'(p_in);
    par_en      = par;
    t = cyc;
    push_frame(t, pe, par, glitch, perr, serr);
    rx_in = 1'b0;
    if (glitch) begin
      tick(1);
      rx_in = 1'b1;
      tick(pe - 1);
      check("glitch_start_held", int'(dat_samp_en), 1);
      tick(1);
      check("glitch_back_idle", int'(dat_samp_en), 0);
      tick(gap);
    end else begin
      bits[0]   = 1'b0;
      bits[8:1] = d;
      bits[9]   = par ? ((^d) ^ perr) : 1'b1;
      bits[10]  = 1'b1;
      nb = par ? 11 : 10;
      for (int i = 0; i < nb; i++) begin
        rx_in = bits[i];
        if (i == 1 && p_switch > 0) prescale = PW'(p_switch);
        repeat (pe) begin
          tick(1);
          if (cyc == t + 1) begin
            check("start_edge_cnt", int'(edge_cnt), 0);
            check("start_samp_en", int'(dat_samp_en), 1);
          end
        end
      end
      rx_in = 1'b1;
      tick(gap);
      if (gap > 1) check("idle_after_frame", int'(dat_samp_en), 0);
    end
  endtask

  // Checker blocks: registered result appears after the strobe cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (strt_chk_en) strt_glitch = cfg_glitch;
      if (par_chk_en)  par_err     = cfg_perr;
      if (stp_chk_en)  stp_err     = cfg_serr;
    end
  end

  // Monitor: every pulse on a strobe or data_valid must match the scoreboard head.
  initial begin
    forever begin
      int n;
      @(negedge clk);
      if (rst) begin
        n = int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en) + int'(data_valid);
        if (n > 0) check("single_pulse", n, 1);
        if (strt_chk_en) expect_ev(EV_STRT);
        if (deser_en)    expect_ev(EV_DATA);
        if (par_chk_en)  expect_ev(EV_PAR);
        if (stp_chk_en)  expect_ev(EV_STOP);
        if (data_valid)  expect_ev(EV_VALID);
      end
    end
  end

  initial begin
    int t;
    rst = 1'b0;
    rx_in = 1'b1;
    prescale = PW'(8);
    par_en = 1'b0;
    strt_glitch = 1'b0;
    par_err = 1'b0;
    stp_err = 1'b0;
    tick(3);
    check("rst_samp_en", int'(dat_samp_en), 0);
    check("rst_edge_cnt", int'(edge_cnt), 0);
    check("rst_strt_chk", int'(strt_chk_en), 0);
    check("rst_deser", int'(deser_en), 0);
    check("rst_par_chk", int'(par_chk_en), 0);
    check("rst_stp_chk", int'(stp_chk_en), 0);
    check("rst_valid", int'(data_valid), 0);
    rst = 1'b1;
    tick(2);

    send_frame(8'h5A,  8, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4);  // clean frame, valid at T+81
    send_frame(8'hC3, 16, 1'b1, 1'b1, 1'b0, 1'b0,  0, 4);  // false start
    send_frame(8'h81,  8, 1'b1, 1'b0, 1'b1, 1'b0,  0, 4);  // parity error
    send_frame(8'h3C,  8, 1'b0, 1'b0, 1'b0, 1'b1,  0, 4);  // stop error
    send_frame(8'hA5, 32, 1'b1, 1'b0, 1'b0, 1'b0,  0, 4);  // longest prescale with parity

    send_frame(8'h11,  8, 1'b0, 1'b0, 1'b0, 1'b0,  0, 1);  // returns in the DONE cycle
    check("b2b_done_valid", int'(data_valid), 1);
    check("b2b_no_idle", int'(dat_samp_en), 1);
    send_frame(8'h22,  8, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4);

    send_frame(8'h96,  8, 1'b0, 1'b0, 1'b0, 1'b0, 16, 4);  // prescale changes mid-frame
    send_frame(8'h69, 16, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4);
    send_frame(8'hF0,  4, 1'b1, 1'b0, 1'b0, 1'b0,  0, 4);  // clamped to 8

    // Reset during data bit 3 (edge 2), before its strobe at edge 5.
    cfg_glitch = 1'b0; cfg_perr = 1'b0; cfg_serr = 1'b0;
    prescale = PW'(8);
    par_en = 1'b0;
    t = cyc;
    push_ev(EV_STRT, t + 6);
    for (int k = 0; k < 3; k++) push_ev(EV_DATA, t + 1 + (k + 1) * 8 + 5);
    rx_in = 1'b0;
    tick(8);
    rx_in = 1'b1;
    tick(27);
    check("pre_rst_edge", int'(edge_cnt), 2);
    check("pre_rst_samp_en", int'(dat_samp_en), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_samp_en", int'(dat_samp_en), 0);
    check("mid_rst_edge_cnt", int'(edge_cnt), 0);
    check("mid_rst_strobes", int'({strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}), 0);
    tick(1);
    rst = 1'b1;
    tick(20);
    check("post_rst_idle", int'(dat_samp_en), 0);
    check("post_rst_edge_cnt", int'(edge_cnt), 0);

    tick(2);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
